// File: rtl/alu64_unit.sv
// Registered integer ALU for the R-type execute stage: logic, add/sub, set-less-than
// and barrel shifts. Result and flags are registered one cycle after the inputs are sampled.
module alu64_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_ALU = 2'b00,
    MODE_SLL = 2'b01,
    MODE_SRL = 2'b10,
    MODE_SRA = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } op_e;

  logic             a_invert;
  logic             b_negate;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             add_cout;
  logic             add_ovf;
  logic             slt_bit;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             ovf_d;

  assign a_invert = alu_ctl[3];
  assign b_negate = alu_ctl[2];
  assign shamt    = b[SHW-1:0];

  // Single shared adder: b_negate both inverts b and supplies the +1 carry-in.
  always_comb begin
    a_in     = a_invert ? ~a : a;
    b_in     = b_negate ? ~b : b;
    sum_full = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, b_negate};
    sum      = sum_full[WIDTH-1:0];
    add_cout = sum_full[WIDTH];
    add_ovf  = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
    // Sign corrected by overflow keeps SLT right at the most-negative/most-positive extremes.
    slt_bit  = sum[WIDTH-1] ^ add_ovf;
  end

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (mode_e'(mode))
      MODE_SLL: res_d = a << shamt;
      MODE_SRL: res_d = a >> shamt;
      MODE_SRA: res_d = $unsigned($signed(a) >>> shamt);
      default: begin
        case (op_e'(alu_ctl))
          OP_AND: res_d = a & b;
          OP_OR:  res_d = a | b;
          OP_NOR: res_d = ~(a | b);
          OP_ADD, OP_SUB: begin
            res_d  = sum;
            cout_d = add_cout;
            ovf_d  = add_ovf;
          end
          OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt_bit};
          default: res_d = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      carryout <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= res_d;
      carryout <= cout_d;
      zero     <= (res_d == '0);
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu64_unit.sv
// Scoreboard bench for alu64_unit: directed corner cases plus random operations,
// checked against an arithmetic reference model.
module tb_alu64_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] result;
  logic        carryout, zero, overflow;
  logic [3:0]  alu_ctl;
  logic [63:0] a, b;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        z;
    logic        v;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu64_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .result(result), .carryout(carryout),
    .zero(zero), .overflow(overflow), .alu_ctl(alu_ctl), .a(a), .b(b), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic rst, input logic [3:0] ctl, input logic [1:0] md,
                                 input logic [63:0] x, input logic [63:0] y, input string nm);
    exp_t e;
    logic [64:0]        u;
    logic signed [64:0] s;
    int unsigned        sh;
    e.r = 64'd0; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.name = nm;
    if (rst) return e;
    sh = y % 64;
    case (md)
      2'b01: e.r = x << sh;
      2'b10: e.r = x >> sh;
      2'b11: e.r = $unsigned($signed(x) >>> sh);
      default: begin
        case (ctl)
          4'b0000: e.r = x & y;
          4'b0001: e.r = x | y;
          4'b1100: e.r = ~(x | y);
          4'b0010: begin
            u = {1'b0, x} + {1'b0, y};
            e.r = u[63:0];
            e.c = u[64];
            s = $signed({x[63], x}) + $signed({y[63], y});
            e.v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
          end
          4'b0110: begin
            e.r = x - y;
            e.c = (x >= y);
            s = $signed({x[63], x}) - $signed({y[63], y});
            e.v = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
          end
          4'b0111: e.r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
          default: e.r = 64'd0;
        endcase
      end
    endcase
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  task automatic issue(input logic rst, input logic [3:0] ctl, input logic [1:0] md,
                       input logic [63:0] x, input logic [63:0] y, input string nm);
    @(posedge clk);
    #2;
    reset = rst; alu_ctl = ctl; mode = md; a = x; b = y;
    sb.push_back(model(rst, ctl, md, x, y, nm));
  endtask

  // Monitor: every edge after an issued operation presents exactly one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (result !== e.r) begin
          failures++;
          $display("FAIL %s result: got %h expected %h", e.name, result, e.r);
        end
        checks++;
        if (carryout !== e.c) begin
          failures++;
          $display("FAIL %s carryout: got %b expected %b", e.name, carryout, e.c);
        end
        checks++;
        if (zero !== e.z) begin
          failures++;
          $display("FAIL %s zero: got %b expected %b", e.name, zero, e.z);
        end
        checks++;
        if (overflow !== e.v) begin
          failures++;
          $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.v);
        end
      end
    end
  end

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h8000_0000_0000_0000;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = '1;
      3: v = 64'd0;
      4: v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] codes [7];
    logic [3:0] c;
    logic [1:0] m;
    int         wait_cycles;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
    codes[4] = 4'b0111; codes[5] = 4'b1100; codes[6] = 4'b0011;
    reset = 1'b1; alu_ctl = 4'b0010; mode = 2'b00; a = 64'd5; b = 64'd5;

    issue(1'b1, 4'b0010, 2'b00, 64'd5, 64'd5, "reset0");
    issue(1'b1, 4'b0010, 2'b00, 64'd5, 64'd5, "reset1");
    issue(1'b0, 4'b0010, 2'b00, 64'd5, 64'd5, "add_after_reset");
    issue(1'b0, 4'b0010, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf");
    issue(1'b0, 4'b0010, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "add_carry");
    issue(1'b0, 4'b0110, 2'b00, 64'd5, 64'd5, "sub_eq");
    issue(1'b0, 4'b0110, 2'b00, 64'd3, 64'd5, "sub_borrow");
    issue(1'b0, 4'b0110, 2'b00, 64'h8000_0000_0000_0000, 64'd1, "sub_ovf");
    issue(1'b0, 4'b0111, 2'b00, 64'h8000_0000_0000_0000, 64'd1, "slt_min");
    issue(1'b0, 4'b0111, 2'b00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "slt_neg");
    issue(1'b0, 4'b0000, 2'b00, 64'hF0F0, 64'h0FF0, "and");
    issue(1'b0, 4'b0001, 2'b00, 64'hF0F0, 64'h0FF0, "or");
    issue(1'b0, 4'b1100, 2'b00, 64'hF0F0, 64'h0FF0, "nor");
    issue(1'b0, 4'b0011, 2'b00, 64'hF0F0, 64'h0FF0, "undef");
    issue(1'b0, 4'b0010, 2'b01, 64'h8000_0000_0000_0010, 64'd4, "sll");
    issue(1'b0, 4'b0110, 2'b10, 64'h8000_0000_0000_0010, 64'd4, "srl");
    issue(1'b0, 4'b0000, 2'b11, 64'h8000_0000_0000_0010, 64'd4, "sra");
    issue(1'b0, 4'b0010, 2'b11, 64'h8000_0000_0000_0010, 64'h40, "sra_shamt0");
    issue(1'b0, 4'b0010, 2'b01, 64'h8000_0000_0000_0010, 64'h40, "sll_shamt0");
    issue(1'b0, 4'b0010, 2'b01, 64'h1, 64'd63, "sll_63");

    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : codes[$urandom_range(0, 6)];
      issue((i % 97) == 50, c, m, rnd64(), rnd64(), "random");
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
